dfe_seq_ctrl: RTL and testbench

- Sequencing controller for the DFE chain: fractional decimator (FD) followed by the notch filter, on the 18 MHz system clock.
- Generates the input-sample strobe, the FD output-valid strobe with its polyphase index, and the notch stage enable.
- Runs the pause/drain/coefficient-reload/flush sequence that reconfigures the notch stage.
- The datapath blocks consume its strobes instead of deriving them from a divided clock.

---
 rtl/dfe_seq_ctrl_if.sv | 21 ++
 rtl/dfe_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dfe_seq_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dfe_seq_ctrl_if.sv
// Coefficient-bank write handshake between the DFE sequencer
// and the notch coefficient store.
interface dfe_seq_ctrl_if #(
    parameter int COEF_AW = 3
);
    logic               coef_we;
    logic [COEF_AW-1:0] coef_addr;
    logic               coef_ack;

    modport master (
        output coef_we,
        output coef_addr,
        input  coef_ack
    );

    modport slave (
        input  coef_we,
        input  coef_addr,
        output coef_ack
    );
endinterface

// File: rtl/dfe_seq_ctrl.sv
// DFE chain sequencer: input/FD strobes, notch enable and the
// pause/drain/coefficient-reload/flush reconfiguration sequence.
module dfe_seq_ctrl #(
    parameter int IN_DIV   = 2,
    parameter int L        = 2,
    parameter int M        = 3,
    parameter int PH_W     = 2,
    parameter int PIPE_LAT = 4,
    parameter int NUM_COEF = 6,
    parameter int COEF_AW  = 3,
    parameter int ACK_TMO  = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            enable,
    input  logic            cfg_start,
    dfe_seq_ctrl_if.master  coef,
    output logic            in_stb,
    output logic            fd_valid,
    output logic [PH_W-1:0] fd_phase,
    output logic            notch_en,
    output logic            flush,
    output logic            cfg_busy,
    output logic            cfg_done,
    output logic            cfg_err,
    output logic [2:0]      state
);

    localparam int DIV_W = (IN_DIV > 2) ? $clog2(IN_DIV) : 1;
    localparam int DRN_W = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
    localparam int TMO_W = (ACK_TMO > 2) ? $clog2(ACK_TMO) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(IN_DIV - 1);
    localparam logic [DRN_W-1:0]   DRN_LAST  = DRN_W'(PIPE_LAT - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(ACK_TMO - 1);
    localparam logic [COEF_AW-1:0] ADDR_LAST = COEF_AW'(NUM_COEF - 1);
    localparam logic [PH_W-1:0]    STEP      = PH_W'(L);
    localparam logic [PH_W-1:0]    WRAP_AT   = PH_W'(M - L);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_LOAD  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DIV_W-1:0]   div_q;
    logic [DRN_W-1:0]   drain_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [COEF_AW-1:0] addr_q;
    logic [PH_W-1:0]    acc_q;
    logic [PH_W-1:0]    phase_q;
    logic               pend_q;
    logic               fdv_q;
    logic               notch_q;
    logic               done_q;
    logic               err_q;

    logic stb_hit;
    logic wrap;
    logic drain_last;
    logic ack_hit;
    logic ack_last;
    logic tmo_hit;

    // acc + L >= M  <=>  acc >= M - L, keeps the math in PH_W bits
    assign stb_hit    = (state_q == S_RUN) && (div_q == DIV_LAST);
    assign wrap       = acc_q >= WRAP_AT;
    assign drain_last = (state_q == S_DRAIN) && (drain_q == DRN_LAST);
    assign ack_hit    = (state_q == S_LOAD) && coef.coef_ack;
    assign ack_last   = ack_hit && (addr_q == ADDR_LAST);
    assign tmo_hit    = (state_q == S_LOAD) && !coef.coef_ack
                        && (tmo_q == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                end else if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_start || !enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_d = pend_q ? S_LOAD : S_IDLE;
                end
            end
            S_LOAD: begin
                if (ack_last) begin
                    state_d = S_FLUSH;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_stb         = stb_hit;
        coef.coef_we   = 1'b0;
        coef.coef_addr = '0;
        flush          = 1'b0;
        cfg_busy       = 1'b0;
        unique case (state_q)
            S_DRAIN: cfg_busy = pend_q;
            S_LOAD: begin
                coef.coef_we   = 1'b1;
                coef.coef_addr = addr_q;
                cfg_busy       = 1'b1;
            end
            S_FLUSH: begin
                flush    = 1'b1;
                cfg_busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q   <= '0;
            drain_q <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            phase_q <= '0;
            pend_q  <= 1'b0;
            fdv_q   <= 1'b0;
            notch_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == S_RUN) && (state_d == S_RUN)) begin
                div_q <= stb_hit ? '0 : div_q + 1'b1;
            end else begin
                div_q <= '0;
            end

            if ((state_q == S_DRAIN) && (state_d == S_DRAIN)) begin
                drain_q <= drain_q + 1'b1;
            end else begin
                drain_q <= '0;
            end

            if ((state_q == S_LOAD) && (state_d == S_LOAD)) begin
                addr_q <= ack_hit ? addr_q + 1'b1 : addr_q;
                tmo_q  <= ack_hit ? '0 : tmo_q + 1'b1;
            end else begin
                addr_q <= '0;
                tmo_q  <= '0;
            end

            if ((state_q == S_RUN) && cfg_start) begin
                pend_q <= 1'b1;
            end else if (state_d == S_IDLE) begin
                pend_q <= 1'b0;
            end

            // a timed-out reload leaves the accumulator untouched
            if (stb_hit) begin
                acc_q <= wrap ? acc_q - WRAP_AT : acc_q + STEP;
            end else if ((state_q == S_FLUSH)
                         || ((state_q == S_DRAIN) && (state_d == S_IDLE))) begin
                acc_q <= '0;
            end

            fdv_q   <= stb_hit && wrap;
            phase_q <= (stb_hit && wrap) ? acc_q - WRAP_AT : '0;
            notch_q <= fdv_q;
            done_q  <= state_q == S_FLUSH;
            err_q   <= tmo_hit;
        end
    end

    assign fd_valid = fdv_q;
    assign fd_phase = phase_q;
    assign notch_en = notch_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_dfe_seq_ctrl.sv
// Bench for dfe_seq_ctrl: cadence table, directed reload corners
// and random episodes against a timeline model.
module tb_dfe_seq_ctrl;

    localparam int IN_DIV   = 2;
    localparam int L        = 2;
    localparam int M        = 3;
    localparam int PH_W     = 2;
    localparam int PIPE_LAT = 4;
    localparam int NUM_COEF = 6;
    localparam int COEF_AW  = 3;
    localparam int ACK_TMO  = 15;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            enable = 1'b0;
    logic            cfg_start = 1'b0;
    logic            in_stb;
    logic            fd_valid;
    logic [PH_W-1:0] fd_phase;
    logic            notch_en;
    logic            flush;
    logic            cfg_busy;
    logic            cfg_done;
    logic            cfg_err;
    logic [2:0]      state;

    dfe_seq_ctrl_if #(.COEF_AW(COEF_AW)) cif ();

    dfe_seq_ctrl #(
        .IN_DIV(IN_DIV), .L(L), .M(M), .PH_W(PH_W),
        .PIPE_LAT(PIPE_LAT), .NUM_COEF(NUM_COEF),
        .COEF_AW(COEF_AW), .ACK_TMO(ACK_TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .enable(enable),
        .cfg_start(cfg_start),
        .coef(cif),
        .in_stb(in_stb),
        .fd_valid(fd_valid),
        .fd_phase(fd_phase),
        .notch_en(notch_en),
        .flush(flush),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic               en;
        logic               cs;
        logic               ack;
        logic [2:0]         st;
        logic               stb;
        logic               fdv;
        logic [PH_W-1:0]    ph;
        logic               ne;
        logic               we;
        logic [COEF_AW-1:0] addr;
        logic               fl;
        logic               busy;
        logic               done;
        logic               err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_stb = 0;
    int n_fdv = 0;

    vec_t tbl[30];
    vec_t tr[$];
    int   dly[NUM_COEF];

    // timeline model state: k = input samples since last acc clear
    int              k = 0;
    logic            p_fdv = 1'b0;
    logic            p_ne = 1'b0;
    logic            p_done = 1'b0;
    logic            p_err = 1'b0;
    logic [PH_W-1:0] p_ph = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t cyc_v(input logic [2:0] st);
        vec_t v;
        v.en = 1'b0; v.cs = 1'b0; v.ack = 1'b0; v.st = st;
        v.stb = 1'b0; v.fdv = 1'b0; v.ph = '0; v.ne = 1'b0;
        v.we = 1'b0; v.addr = '0; v.fl = 1'b0; v.busy = 1'b0;
        v.done = 1'b0; v.err = 1'b0;
        return v;
    endfunction

    function automatic vec_t tv(input logic en, input logic [2:0] st,
                                input logic stb, input logic fdv,
                                input int ph, input logic ne);
        vec_t v;
        v = cyc_v(st);
        v.en = en; v.stb = stb; v.fdv = fdv;
        v.ph = PH_W'(ph); v.ne = ne;
        return v;
    endfunction

    function automatic logic [15:0] pack_exp(input vec_t v);
        return {v.stb, v.fdv, v.ph & {PH_W{v.fdv}}, v.ne, v.we,
                v.addr & {COEF_AW{v.we}}, v.fl, v.busy, v.done,
                v.err, v.st};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h exp %h", nm, cyc, got, exp);
        end
    endtask

    task automatic apply_check(input vec_t v, input string nm);
        logic [15:0] got;
        enable = v.en;
        cfg_start = v.cs;
        cif.coef_ack = v.ack;
        @(negedge CLK);
        got = {in_stb, fd_valid, fd_phase & {PH_W{v.fdv}}, notch_en,
               cif.coef_we, cif.coef_addr & {COEF_AW{v.we}}, flush,
               cfg_busy, cfg_done, cfg_err, state};
        if (in_stb) n_stb++;
        if (fd_valid) n_fdv++;
        chk(nm, got, pack_exp(v));
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    // every strobe shows up on fd_valid one cycle later exactly when
    // floor(k*L/M) steps, with phase (k*L) mod M
    function automatic void push(input vec_t vi);
        vec_t v;
        v = vi;
        v.fdv = p_fdv; v.ph = p_ph; v.ne = p_ne;
        v.done = p_done; v.err = p_err;
        p_done = 1'b0;
        p_err = 1'b0;
        p_ne = p_fdv;
        if (v.stb) begin
            k++;
            p_fdv = ((k * L) / M) != (((k - 1) * L) / M);
            p_ph = PH_W'((k * L) % M);
        end else begin
            p_fdv = 1'b0;
            p_ph = '0;
        end
        tr.push_back(v);
    endfunction

    function automatic vec_t ld(input int a, input logic ack);
        vec_t v;
        v = cyc_v(3'd3);
        v.we = 1'b1; v.addr = COEF_AW'(a); v.busy = 1'b1;
        v.ack = ack; v.en = rb(); v.cs = rb();
        return v;
    endfunction

    function automatic void do_load();
        vec_t v;
        for (int a = 0; a < NUM_COEF; a++) begin
            if (dly[a] >= ACK_TMO) begin
                for (int c = 0; c < ACK_TMO; c++) push(ld(a, 1'b0));
                p_err = 1'b1;
                return;
            end
            for (int c = 0; c < dly[a]; c++) push(ld(a, 1'b0));
            push(ld(a, 1'b1));
        end
        v = cyc_v(3'd4);
        v.fl = 1'b1; v.busy = 1'b1;
        v.en = rb(); v.cs = rb(); v.ack = rb();
        push(v);
        k = 0;
        p_done = 1'b1;
    endfunction

    function automatic void ep_idle(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = cyc_v(3'd0);
            v.ack = rb();
            push(v);
        end
    endfunction

    // ex: 0 = enable drop, 1 = cfg_start, 2 = cfg_start with enable drop
    function automatic void ep_run(input int r, input int ex);
        vec_t v;
        v = cyc_v(3'd0);
        v.en = 1'b1; v.ack = rb();
        push(v);
        for (int j = 1; j <= r; j++) begin
            v = cyc_v(3'd1);
            v.en = (j < r) || (ex == 1);
            v.cs = (j == r) && (ex != 0);
            v.stb = (j % IN_DIV) == 0;
            v.ack = rb();
            push(v);
        end
        for (int d = 0; d < PIPE_LAT; d++) begin
            v = cyc_v(3'd2);
            v.busy = ex != 0;
            v.en = rb(); v.cs = rb(); v.ack = rb();
            push(v);
        end
        if (ex == 0) k = 0;
        else do_load();
    endfunction

    function automatic void ep_load();
        vec_t v;
        v = cyc_v(3'd0);
        v.cs = 1'b1; v.en = rb(); v.ack = rb();
        push(v);
        do_load();
    endfunction

    function automatic void set_dly(input int d);
        for (int a = 0; a < NUM_COEF; a++) dly[a] = d;
    endfunction

    function automatic void rnd_dly();
        for (int a = 0; a < NUM_COEF; a++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 14) dly[a] = int'($urandom_range(0, 4));
            else if (r < 16) dly[a] = ACK_TMO - 1;
            else if (r < 19) dly[a] = 0;
            else dly[a] = ACK_TMO + int'($urandom_range(0, 2));
        end
    endfunction

    task automatic play(input string nm);
        foreach (tr[i]) apply_check(tr[i], nm);
        tr.delete();
    endtask

    initial begin
        vec_t v;
        int   sel;

        tbl[0]  = tv(1, 0, 0, 0, 0, 0);
        tbl[1]  = tv(1, 1, 0, 0, 0, 0);
        tbl[2]  = tv(1, 1, 1, 0, 0, 0);
        tbl[3]  = tv(1, 1, 0, 0, 0, 0);
        tbl[4]  = tv(1, 1, 1, 0, 0, 0);
        tbl[5]  = tv(1, 1, 0, 1, 1, 0);
        tbl[6]  = tv(1, 1, 1, 0, 0, 1);
        tbl[7]  = tv(1, 1, 0, 1, 0, 0);
        tbl[8]  = tv(1, 1, 1, 0, 0, 1);
        tbl[9]  = tv(1, 1, 0, 0, 0, 0);
        tbl[10] = tv(0, 1, 1, 0, 0, 0);
        tbl[11] = tv(0, 2, 0, 1, 1, 0);
        tbl[12] = tv(0, 2, 0, 0, 0, 1);
        tbl[13] = tv(0, 2, 0, 0, 0, 0);
        tbl[14] = tv(0, 2, 0, 0, 0, 0);
        tbl[15] = tv(0, 0, 0, 0, 0, 0);
        tbl[16] = tv(1, 0, 0, 0, 0, 0);
        tbl[17] = tv(1, 1, 0, 0, 0, 0);
        tbl[18] = tv(1, 1, 1, 0, 0, 0);
        tbl[19] = tv(1, 1, 0, 0, 0, 0);
        tbl[20] = tv(1, 1, 1, 0, 0, 0);
        tbl[21] = tv(1, 1, 0, 1, 1, 0);
        tbl[22] = tv(1, 1, 1, 0, 0, 1);
        tbl[23] = tv(1, 1, 0, 1, 0, 0);
        tbl[24] = tv(0, 1, 1, 0, 0, 1);
        tbl[25] = tv(0, 2, 0, 0, 0, 0);
        tbl[26] = tv(0, 2, 0, 0, 0, 0);
        tbl[27] = tv(0, 2, 0, 0, 0, 0);
        tbl[28] = tv(0, 2, 0, 0, 0, 0);
        tbl[29] = tv(0, 0, 0, 0, 0, 0);

        RST = 1'b1;
        cif.coef_ack = 1'b0;
        @(posedge CLK);
        #1;
        v = cyc_v(3'd0);
        v.en = 1'b1; v.cs = 1'b1; v.ack = 1'b1;
        apply_check(v, "reset");
        apply_check(v, "reset");
        RST = 1'b0;

        for (int i = 0; i < 30; i++) begin
            apply_check(tbl[i], $sformatf("cadence%0d", i));
        end

        set_dly(0);
        ep_run(6, 1);
        ep_run(5, 0);
        play("reload_ack_high");

        set_dly(3);
        ep_run(7, 1);
        play("slow_ack");

        set_dly(0);
        dly[0] = ACK_TMO + 5;
        ep_run(4, 1);
        ep_idle(3);
        play("timeout");

        set_dly(0);
        ep_run(9, 2);
        set_dly(ACK_TMO - 1);
        ep_load();
        set_dly(0);
        dly[NUM_COEF-1] = ACK_TMO;
        ep_load();
        ep_idle(2);
        ep_run(2, 0);
        play("corner");

        n_stb = 0;
        n_fdv = 0;
        ep_run(20001, 0);
        play("long_run");
        chk("stb_count", 16'(n_stb), 16'd10000);
        chk("fdv_count", 16'(n_fdv), 16'd6666);

        for (int e = 0; e < 80; e++) begin
            sel = int'($urandom_range(0, 5));
            rnd_dly();
            if (sel == 0) ep_idle(int'($urandom_range(1, 4)));
            else if (sel == 1) ep_load();
            else ep_run(int'($urandom_range(1, 30)),
                        int'($urandom_range(0, 2)));
        end
        play("random");

        v = cyc_v(3'd0);
        v.cs = 1'b1;
        push(v);
        for (int a = 0; a < 3; a++) push(ld(a, 1'b1));
        push(ld(3, 1'b0));
        play("pre_reset_load");

        RST = 1'b1;
        enable = 1'b1;
        cfg_start = 1'b0;
        cif.coef_ack = 1'b1;
        @(negedge CLK);
        chk("load_addr3", {12'd0, cif.coef_we, cif.coef_addr},
            {12'd0, 1'b1, 3'd3});
        @(posedge CLK);
        #1;
        chk("reset_in_load",
            {in_stb, fd_valid, fd_phase, notch_en, cif.coef_we,
             cif.coef_addr, flush, cfg_busy, cfg_done, cfg_err, state},
            16'd0);
        RST = 1'b0;
        k = 0;
        p_fdv = 1'b0; p_ne = 1'b0; p_done = 1'b0; p_err = 1'b0;
        ep_idle(3);
        play("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
